// File: rtl/calc_key_pkg.sv
// calc_key_pkg: key codes and helpers shared by the key encoder and the calculator FSM
package calc_key_pkg;
  typedef logic [3:0] key_code_t;
  localparam int NUM_KEYS = 12;
  localparam key_code_t KEY_ADD = 4'hA;
  localparam key_code_t KEY_SUB = 4'hB;
  localparam logic [NUM_KEYS-1:0] DIGIT_MASK = 12'h3FF;
  // Input index doubles as key code: 0-9 digits, 10 add, 11 sub
  function automatic key_code_t first_set(input logic [NUM_KEYS-1:0] v);
    first_set = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (v[i]) first_set = key_code_t'(i);
  endfunction
endpackage

// File: rtl/calc_key_debounce.sv
// calc_key_debounce: 2-FF synchroniser, stability counter and registered rising-edge pulse
module calc_key_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic lvl_q, lvl_dly_q, rise_q;
  // Level flips only after CYCLES consecutive samples disagree with it; pulse lags one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw};
      lvl_dly_q <= lvl_q;
      rise_q    <= lvl_q & ~lvl_dly_q;
      if (sync_q[1] == lvl_q) cnt_q <= '0;
      else if (cnt_q == LAST) begin
        cnt_q <= '0;
        lvl_q <= ~lvl_q;
      end else cnt_q <= cnt_q + CW'(1);
    end
  end
  assign level = lvl_q;
  assign rise  = rise_q;
endmodule

// File: rtl/calc_key_encoder.sv
// calc_key_encoder: debounced switch/button front-end feeding a key-code FIFO (optional KEY_REPEAT_EN auto-repeat)
module calc_key_encoder
  import calc_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [9:0]                        switch,
  input  logic                              op_add,
  input  logic                              op_sub,
  output logic                              key_valid,
  output key_code_t                         key_code,
  input  logic                              key_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  logic [NUM_KEYS-1:0] raw, lvl, rise, rep_ev, clr, pend_q, pend_d;
  key_code_t mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] cnt_q;
  logic ovf_q, ovf_d, push, pop;
  key_code_t sel;
  assign raw = {op_sub, op_add, switch};
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
    calc_key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock(clock),
      .reset(reset),
      .raw  (raw[i]),
      .level(lvl[i]),
      .rise (rise[i])
    );
  end
`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic [NUM_KEYS-1:0] held;
  key_code_t low, rep_idx_q;
  logic [RW-1:0] rep_cnt_q;
  logic rep_first_q, rep_track, rep_hit;
  assign held      = lvl & DIGIT_MASK;
  assign low       = first_set(held);
  assign rep_track = (held != '0) && (low == rep_idx_q);
  assign rep_hit   = rep_track && (rep_cnt_q == (rep_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1)));
  assign rep_ev    = rep_hit ? (NUM_KEYS'(1) << low) : '0;
  // Repeat timer restarts whenever the lowest held digit changes or nothing is held
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep_idx_q   <= '0;
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (!rep_track) begin
      rep_idx_q   <= low;
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (rep_hit) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else rep_cnt_q <= rep_cnt_q + RW'(1);
  end
`else
  localparam int unused_rep = REPEAT_DELAY + REPEAT_RATE;
  logic unused_lvl;
  assign unused_lvl = ^lvl;
  assign rep_ev     = '0;
`endif
  // Lowest pending index wins; a full FIFO still accepts a push when it pops the same cycle
  always_comb begin
    pop    = (cnt_q != '0) && key_ready;
    sel    = first_set(pend_q);
    push   = (pend_q != '0) && ((cnt_q != LW'(FIFO_DEPTH)) || pop);
    clr    = push ? (NUM_KEYS'(1) << sel) : '0;
    pend_d = (pend_q & ~clr) | rise | rep_ev;
    ovf_d  = ovf_q | (|(rise & pend_q & ~clr));
  end
  // Pending bits, sticky overflow and the circular key-code FIFO
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_q + LW'(push) - LW'(pop);
      if (pop) rd_q <= rd_q + PW'(1);
      if (push) begin
        mem_q[wr_q] <= sel;
        wr_q        <= wr_q + PW'(1);
      end
    end
  end
  assign key_valid  = cnt_q != '0;
  assign key_code   = mem_q[rd_q];
  assign fifo_level = cnt_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_calc_key_encoder.sv
// tb_calc_key_encoder: directed scenarios for the key encoder (expects default parameters)
module tb_calc_key_encoder;
  localparam int DEB = 16;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [9:0] switch = '0;
  logic op_add = 1'b0;
  logic op_sub = 1'b0;
  logic key_ready = 1'b0;
  logic key_valid;
  logic [3:0] key_code;
  logic [2:0] fifo_level;
  logic overflow;
  int vectors = 0;
  int errors = 0;

  calc_key_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH     (4),
    .REPEAT_DELAY   (64),
    .REPEAT_RATE    (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .switch    (switch),
    .op_add    (op_add),
    .op_sub    (op_sub),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_key(input int k, input logic v);
    @(negedge clock);
    if (k < 10) switch[k] = v;
    else if (k == 10) op_add = v;
    else op_sub = v;
  endtask

  task automatic press(input int k);
    set_key(k, 1'b1);
    repeat (29) @(negedge clock);
    set_key(k, 1'b0);
    repeat (30) @(negedge clock);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    vectors += 4;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h want 0", key_code); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_clean_press;
    int n, extra;
    key_ready = 1'b1;
    set_key(3, 1'b1);
    n = 0;
    while (n < 40 && key_valid !== 1'b1) begin
      @(posedge clock);
      #1;
      n++;
    end
    vectors += 2;
    if (n != DEB + 5) begin errors++; $display("FAIL clean_latency: got %0d edges want %0d", n, DEB + 5); end
    if (key_code !== 4'h3) begin errors++; $display("FAIL clean_code: got %h want 3", key_code); end
    @(posedge clock);
    #1;
    vectors++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL clean_one_cycle: got %b want 0", key_valid); end
    extra = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (c == 15) switch[3] = 1'b0;
      if (key_valid === 1'b1) extra++;
    end
    vectors += 2;
    if (extra != 0) begin errors++; $display("FAIL clean_no_release_event: got %0d events want 0", extra); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL clean_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_glitch;
    int seen;
    key_ready = 1'b0;
    set_key(10, 1'b1);
    repeat (9) @(negedge clock);
    set_key(10, 1'b0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (key_valid === 1'b1 || fifo_level !== 3'd0) seen++;
    end
    vectors += 2;
    if (seen != 0) begin errors++; $display("FAIL glitch_event: got %0d busy cycles want 0", seen); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL glitch_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_sequence;
    logic [3:0] got [8];
    logic [3:0] want [5];
    int n;
    want[0] = 4'h3; want[1] = 4'hA; want[2] = 4'h5; want[3] = 4'hB; want[4] = 4'h8;
    key_ready = 1'b0;
    press(3); press(10); press(5); press(11); press(8);
    vectors += 4;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL seq_full_level: got %0d want 4", fifo_level); end
    if (key_valid !== 1'b1) begin errors++; $display("FAIL seq_valid_held: got %b want 1", key_valid); end
    if (key_code !== 4'h3) begin errors++; $display("FAIL seq_head_held: got %h want 3", key_code); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL seq_overflow: got %b want 0", overflow); end
    key_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (key_valid === 1'b1 && n < 8) begin got[n] = key_code; n++; end
      @(negedge clock);
    end
    vectors++;
    if (n != 5) begin errors++; $display("FAIL seq_count: got %0d codes want 5", n); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= n || got[i] !== want[i]) begin
        errors++;
        $display("FAIL seq_code%0d: got %h want %h", i, (i < n) ? got[i] : 4'hx, want[i]);
      end
    end
    vectors += 2;
    if (overflow !== 1'b0) begin errors++; $display("FAIL seq_overflow_end: got %b want 0", overflow); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL seq_drained: got %0d want 0", fifo_level); end
  endtask

  task automatic test_simultaneous;
    logic [3:0] got [8];
    int cyc [8];
    int n;
    key_ready = 1'b1;
    @(negedge clock);
    switch[7] = 1'b1;
    switch[2] = 1'b1;
    op_sub = 1'b1;
    n = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clock);
      if (c == 30) begin switch[7] = 1'b0; switch[2] = 1'b0; op_sub = 1'b0; end
      if (key_valid === 1'b1 && n < 8) begin got[n] = key_code; cyc[n] = c; n++; end
    end
    vectors += 5;
    if (n != 3) begin errors++; $display("FAIL sim_count: got %0d codes want 3", n); end
    if (got[0] !== 4'h2) begin errors++; $display("FAIL sim_code0: got %h want 2", got[0]); end
    if (got[1] !== 4'h7) begin errors++; $display("FAIL sim_code1: got %h want 7", got[1]); end
    if (got[2] !== 4'hB) begin errors++; $display("FAIL sim_code2: got %h want b", got[2]); end
    if (n >= 3 && cyc[2] - cyc[0] != 2) begin errors++; $display("FAIL sim_consecutive: got span %0d want 2", cyc[2] - cyc[0]); end
    else if (n < 3) begin errors++; $display("FAIL sim_consecutive: got %0d codes want 3", n); end
  endtask

  task automatic test_overflow;
    key_ready = 1'b0;
    press(0); press(1); press(2); press(3); press(5);
    vectors += 2;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_full: got %0d want 4", fifo_level); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b want 0", overflow); end
    press(5);
    vectors++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    repeat (20) @(negedge clock);
    vectors += 2;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level_held: got %0d want 4", fifo_level); end
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    vectors += 4;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", key_valid); end
    if (key_code !== 4'h0) begin errors++; $display("FAIL async_code: got %h want 0", key_code); end
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL async_level: got %0d want 0", fifo_level); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL async_overflow: got %b want 0", overflow); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_repeat;
    int nines;
    key_ready = 1'b1;
    nines = 0;
    set_key(9, 1'b1);
    for (int c = 0; c < 260; c++) begin
      @(negedge clock);
      if (c == 199) switch[9] = 1'b0;
      if (key_valid === 1'b1 && key_code === 4'h9) nines++;
    end
    vectors++;
`ifdef KEY_REPEAT_EN
    if (nines < 5) begin errors++; $display("FAIL repeat_count: got %0d nines want at least 5", nines); end
`else
    if (nines != 1) begin errors++; $display("FAIL repeat_count: got %0d nines want 1", nines); end
`endif
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_glitch;
    test_sequence;
    test_simultaneous;
    test_overflow;
    test_repeat;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
